// File: rtl/cc_banks_param_ext.sv
// cc_banks_param_ext: banked single-port RAM wrapper with byte masks, valid/ready requests, optional output register and post-reset init sweep
package cc_banks_param_ext_pkg;
  typedef struct packed {
    logic [3:0] rm;
    logic       rme;
    logic       test1;
    logic       ls;
    logic       ds;
  } mem_ctrl_sasrl_1p_t;
endpackage

module cc_banks_param_ext
  import cc_banks_param_ext_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int ADDR_W        = 13,
  parameter int NBANKS        = 4,
  parameter int OUT_REG       = 0,
  parameter int INIT_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                RW0_clk,
  input  logic                RW0_rst,
  input  logic                RW0_req_valid,
  output logic                RW0_req_ready,
  input  logic [ADDR_W-1:0]   RW0_addr,
  input  logic                RW0_wmode,
  input  logic [DATA_W-1:0]   RW0_wdata,
  input  logic [DATA_W/8-1:0] RW0_wmask,
  output logic                RW0_rvalid,
  output logic [DATA_W-1:0]   RW0_rdata,
  output logic                init_busy,
  input  mem_ctrl_sasrl_1p_t  mem_ctrl_sasrl
);
  localparam int SEL_W   = $clog2(NBANKS);
  localparam int BANK_AW = ADDR_W - SEL_W;
  localparam int NB      = DATA_W / 8;

  typedef enum logic {INIT, RUN} state_t;

  state_t             state_q, state_d;
  logic [BANK_AW-1:0] cnt_q, cnt_d;
  logic               acc, init_wr;
  logic [SEL_W-1:0]   sel, sel_q;
  logic [BANK_AW-1:0] row, wrow;
  logic [NB-1:0]      wbe;
  logic [DATA_W-1:0]  wd;
  logic [NBANKS-1:0]  we, re;
  logic [DATA_W-1:0]  dout [NBANKS];
  mem_ctrl_sasrl_1p_t bank_sasrl [NBANKS];
  logic               rd_q, rv1_q, rv_out;
  logic [DATA_W-1:0]  rd1_q, rdat;

  assign sel           = RW0_addr[ADDR_W-1 -: SEL_W];
  assign row           = RW0_addr[BANK_AW-1:0];
  assign RW0_req_ready = (state_q == RUN) && !RW0_rst;
  assign init_busy     = RW0_rst ? (INIT_ON_RESET != 0) : (state_q == INIT);
  assign acc           = RW0_req_valid && RW0_req_ready;
  assign init_wr       = (state_q == INIT) && !RW0_rst;

  // sweep row counter advances each INIT cycle; last row hands over to RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (init_wr) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = &cnt_q ? RUN : INIT;
    end
  end

  // FSM and sweep counter registers
  always_ff @(posedge RW0_clk) begin
    if (RW0_rst) begin
      state_q <= (INIT_ON_RESET != 0) ? INIT : RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // the sweep owns the write port in INIT, requests own it in RUN
  always_comb begin
    wrow = init_wr ? cnt_q : row;
    wd   = init_wr ? INIT_VALUE : RW0_wdata;
    wbe  = init_wr ? '1 : RW0_wmask;
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [2**BANK_AW];
    logic              unused_sasrl_b;
    assign we[b]          = init_wr || (acc && RW0_wmode && (sel == SEL_W'(b)));
    assign re[b]          = acc && !RW0_wmode && (sel == SEL_W'(b));
    assign bank_sasrl[b]  = mem_ctrl_sasrl;
    assign unused_sasrl_b = ^bank_sasrl[b];
    // byte-masked write and registered read; bank is touched only when enabled
    always_ff @(posedge RW0_clk) begin
      for (int i = 0; i < NB; i++)
        if (we[b] && wbe[i]) mem[wrow][i*8 +: 8] <= wd[i*8 +: 8];
      if (re[b]) dout[b] <= mem[row];
    end
  end

  // request stage: remember that a read went out and which bank serves it
  always_ff @(posedge RW0_clk) begin
    if (RW0_rst) begin
      rd_q  <= 1'b0;
      sel_q <= '0;
    end else begin
      rd_q <= acc && !RW0_wmode;
      if (acc) sel_q <= sel;
    end
  end

  // return stage: select bank output, hold data until the next read returns
  always_ff @(posedge RW0_clk) begin
    if (RW0_rst) begin
      rv1_q <= 1'b0;
      rd1_q <= '0;
    end else begin
      rv1_q <= rd_q;
      if (rd_q) rd1_q <= dout[sel_q];
    end
  end

  if (OUT_REG != 0) begin : g_out
    logic              rv2_q;
    logic [DATA_W-1:0] rd2_q;
    // optional extra output register stage
    always_ff @(posedge RW0_clk) begin
      if (RW0_rst) begin
        rv2_q <= 1'b0;
        rd2_q <= '0;
      end else begin
        rv2_q <= rv1_q;
        if (rv1_q) rd2_q <= rd1_q;
      end
    end
    assign rv_out = rv2_q;
    assign rdat   = rd2_q;
  end else begin : g_noout
    assign rv_out = rv1_q;
    assign rdat   = rd1_q;
  end

  assign RW0_rvalid = rv_out && !RW0_rst;
  assign RW0_rdata  = RW0_rst ? '0 : rdat;
endmodule

// File: tb/tb_cc_banks_param_ext.sv
// tb_cc_banks_param_ext: vector table plus scoreboard bench for the banked RAM wrapper
module tb_cc_banks_param_ext;
  import cc_banks_param_ext_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, valid = 1'b0, ready, wmode = 1'b0, rvalid, busy;
  logic [12:0] addr = '0;
  logic [63:0] wdata = '0, rdata;
  logic [7:0]  wmask = '0;
  logic        b_rst = 1'b1, b_valid = 1'b0, b_ready, b_wmode = 1'b0, b_rvalid, b_busy;
  logic [12:0] b_addr = '0;
  logic [63:0] b_wdata = '0, b_rdata;
  logic [7:0]  b_wmask = '0;
  mem_ctrl_sasrl_1p_t sasrl = '0;

  cc_banks_param_ext u0 (
    .RW0_clk(clk), .RW0_rst(rst), .RW0_req_valid(valid), .RW0_req_ready(ready),
    .RW0_addr(addr), .RW0_wmode(wmode), .RW0_wdata(wdata), .RW0_wmask(wmask),
    .RW0_rvalid(rvalid), .RW0_rdata(rdata), .init_busy(busy), .mem_ctrl_sasrl(sasrl)
  );

  cc_banks_param_ext #(.OUT_REG(1), .INIT_ON_RESET(0)) u1 (
    .RW0_clk(clk), .RW0_rst(b_rst), .RW0_req_valid(b_valid), .RW0_req_ready(b_ready),
    .RW0_addr(b_addr), .RW0_wmode(b_wmode), .RW0_wdata(b_wdata), .RW0_wmask(b_wmask),
    .RW0_rvalid(b_rvalid), .RW0_rdata(b_rdata), .init_busy(b_busy), .mem_ctrl_sasrl(sasrl)
  );

  typedef struct {
    logic [12:0] addr;
    logic        wr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  vec_t vt[22];
  exp_t sbq[$];
  int   cyc = 0, pass_n = 0, chk_n = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // every rvalid pulse must match the oldest outstanding read, on its due cycle
  always @(negedge clk) begin
    exp_t e;
    if (rvalid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk_n++;
        $display("FAIL spurious_rvalid: got rvalid=1 with no read outstanding, expected 0");
      end else begin
        e = sbq.pop_front();
        check("rdata", rdata, e.data);
        check("rd_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic issue(input logic [12:0] a, input logic w, input logic [63:0] d,
                       input logic [7:0] m, input logic [63:0] e);
    valid = 1'b1; addr = a; wmode = w; wdata = d; wmask = m;
    if (!w) sbq.push_back('{e, cyc + 2});
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(ready), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_rdata", rdata, 64'h0);
    check("rst_busy", 64'(busy), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_init(input string nm);
    int n = 0, bad = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      n++;
      if (ready) bad++;
      @(negedge clk);
    end
    check({nm, "_busy_cycles"}, 64'(n), 64'(2048));
    check({nm, "_ready_in_init"}, 64'(bad), 64'(0));
    check({nm, "_ready_after"}, 64'(ready), 64'(1));
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(sbq.size()), 64'(0));
  endtask

  initial begin
    logic [63:0] last;
    int seen;
    vt[0]  = '{13'h0000, 1'b0, 64'h0, 8'h00, 64'h0};
    vt[1]  = '{13'h0FFF, 1'b0, 64'h0, 8'h00, 64'h0};
    vt[2]  = '{13'h1FFF, 1'b0, 64'h0, 8'h00, 64'h0};
    vt[3]  = '{13'h0801, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'hFF, 64'h0};
    vt[4]  = '{13'h0801, 1'b0, 64'h0, 8'h00, 64'h1234_5678_9ABC_DEF0};
    vt[5]  = '{13'h1003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0};
    vt[6]  = '{13'h1003, 1'b1, 64'h0, 8'h0F, 64'h0};
    vt[7]  = '{13'h1003, 1'b0, 64'h0, 8'h00, 64'hFFFF_FFFF_0000_0000};
    vt[8]  = '{13'h0000, 1'b1, 64'hA0A0_0000_0000_00A0, 8'hFF, 64'h0};
    vt[9]  = '{13'h0800, 1'b1, 64'hB1B1_1111_0000_00B1, 8'hFF, 64'h0};
    vt[10] = '{13'h1000, 1'b1, 64'hC2C2_2222_0000_00C2, 8'hFF, 64'h0};
    vt[11] = '{13'h1800, 1'b1, 64'hD3D3_3333_0000_00D3, 8'hFF, 64'h0};
    vt[12] = '{13'h0000, 1'b0, 64'h0, 8'h00, 64'hA0A0_0000_0000_00A0};
    vt[13] = '{13'h0800, 1'b0, 64'h0, 8'h00, 64'hB1B1_1111_0000_00B1};
    vt[14] = '{13'h1000, 1'b0, 64'h0, 8'h00, 64'hC2C2_2222_0000_00C2};
    vt[15] = '{13'h1800, 1'b0, 64'h0, 8'h00, 64'hD3D3_3333_0000_00D3};
    vt[16] = '{13'h0801, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0};
    vt[17] = '{13'h0801, 1'b0, 64'h0, 8'h00, 64'h1234_5678_9ABC_DEF0};
    vt[18] = '{13'h0002, 1'b1, 64'h5555_AAAA_0123_4567, 8'hF0, 64'h0};
    vt[19] = '{13'h0002, 1'b0, 64'h0, 8'h00, 64'h5555_AAAA_0000_0000};
    vt[20] = '{13'h0003, 1'b0, 64'h0, 8'h00, 64'h0};
    vt[21] = '{13'h1802, 1'b0, 64'h0, 8'h00, 64'h0};

    @(posedge clk); #1;
    do_reset();
    wait_init("init1");

    last = '0;
    foreach (vt[i]) begin
      issue(vt[i].addr, vt[i].wr, vt[i].wdata, vt[i].wmask, vt[i].exp);
      if (!vt[i].wr) last = vt[i].exp;
    end
    drain();
    repeat (3) @(negedge clk);
    check("rdata_hold", rdata, last);
    check("rvalid_idle", 64'(rvalid), 64'(0));

    @(posedge clk); #1;
    do_reset();
    repeat (1000) @(posedge clk);
    #1;
    do_reset();
    wait_init("init2");
    issue(13'h0801, 1'b0, 64'h0, 8'h00, 64'h0);
    issue(13'h1003, 1'b0, 64'h0, 8'h00, 64'h0);
    drain();

    @(posedge clk); #1;
    @(negedge clk);
    check("b_rst_ready", 64'(b_ready), 64'(0));
    check("b_rst_busy", 64'(b_busy), 64'(0));
    @(posedge clk); #1;
    b_rst = 1'b0;
    @(negedge clk);
    check("b_ready", 64'(b_ready), 64'(1));
    b_valid = 1'b1; b_addr = 13'h0805; b_wmode = 1'b1;
    b_wdata = 64'hCAFE_F00D_DEAD_BEEF; b_wmask = 8'hFF;
    @(posedge clk); #1;
    b_wmode = 1'b0;
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    check("b_lat_c0", 64'(b_rvalid), 64'(0));
    @(negedge clk);
    check("b_lat_c1", 64'(b_rvalid), 64'(0));
    @(negedge clk);
    check("b_lat_c2", 64'(b_rvalid), 64'(1));
    check("b_rdata", b_rdata, 64'hCAFE_F00D_DEAD_BEEF);
    @(negedge clk);
    check("b_pulse_end", 64'(b_rvalid), 64'(0));

    @(posedge clk); #1;
    b_valid = 1'b1; b_addr = 13'h0805; b_wmode = 1'b0;
    @(posedge clk); #1;
    b_valid = 1'b0;
    b_rst = 1'b1;
    @(posedge clk); #1;
    b_rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (b_rvalid) seen++;
    end
    check("b_flush_rvalid", 64'(seen), 64'(0));
    check("b_flush_rdata", b_rdata, 64'h0);

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end
endmodule
